led_strip_streamer: RTL and testbench

// - Downstream of the frame-buffer RAM (SB_RAM512x8, read port on clk_sys). Replaces the direct sdo = rdata[0] tap.
// - Reads one frame of per-LED B,G,R bytes on send_req.
// - Serialises the frame as an APA102 (DotStar) stream on clk_out/sdo.
// - Frame layout: 32-bit start frame, then per LED {3'b111, brightness[4:0]}, B, G, R, then an end frame of 1s.

---
 rtl/led_wheel_pkg.sv | 9 +
 rtl/led_bit_timer.sv | 32 +++
 rtl/led_strip_streamer.sv | 120 ++++++++++++
 tb/tb_led_strip_streamer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_wheel_pkg.sv
// led_wheel_pkg: APA102 framing constants, streamer FSM states and end-frame length helper
package led_wheel_pkg;
    localparam int APA102_START_BITS = 32;
    localparam logic [2:0] APA102_HDR_MARK = 3'b111;
    typedef enum logic [2:0] {IDLE, START, HDR, BLUE, GREEN, RED, END} state_t;
    function automatic int end_bits(input int n_leds);
        return 8 * ((n_leds + 15) / 16);
    endfunction
endpackage

// File: rtl/led_bit_timer.sv
// led_bit_timer: divides clk_sys into APA102 bit periods, low half then high half, with bit strobes
module led_bit_timer #(
    parameter int DIV_WIDTH = 4
) (
    input  logic                 clk_sys,
    input  logic                 n_reset,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 clk_out,
    output logic                 bit_start,
    output logic                 bit_end
);
    logic [DIV_WIDTH-1:0] cnt;
    logic                 half;
    always_ff @(posedge clk_sys or negedge n_reset) begin
        if (!n_reset) begin
            cnt  <= '0;
            half <= 1'b0;
        end else if (!run) begin
            cnt  <= '0;
            half <= 1'b0;
        end else if (cnt == div) begin
            cnt  <= '0;
            half <= ~half;
        end else begin
            cnt <= cnt + DIV_WIDTH'(1);
        end
    end
    assign clk_out   = half;
    assign bit_start = run && !half && cnt == '0;
    assign bit_end   = run && half && cnt == div;
endmodule

// File: rtl/led_strip_streamer.sv
// led_strip_streamer: reads one frame of B,G,R bytes from RAM and streams it as APA102 on clk_out/sdo
module led_strip_streamer
    import led_wheel_pkg::*;
#(
    parameter int N_LEDS     = 320,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 4
) (
    input  logic                  clk_sys,
    input  logic                  n_reset,
    input  logic                  send_req,
    input  logic [4:0]            brightness,
    input  logic [DIV_WIDTH-1:0]  div,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  read_en,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  clk_out,
    output logic                  sdo,
    output logic                  busy,
    output logic                  done
);
    localparam int END_BYTES = end_bits(N_LEDS) / 8;
    localparam int LED_WIDTH = $clog2(N_LEDS + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(3 * N_LEDS - 1);

    if (3 * N_LEDS > 2 ** ADDR_WIDTH) begin : g_addr_chk
        $error("led_strip_streamer: 3*N_LEDS does not fit in ADDR_WIDTH");
    end
    if (DATA_WIDTH != 8) begin : g_data_chk
        $error("led_strip_streamer: DATA_WIDTH must be 8");
    end

    state_t               state, nxt;
    logic [5:0]           bcnt;
    logic [LED_WIDTH-1:0] led_cnt;
    logic [7:0]           sh, hold;
    logic [4:0]           bri_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 rd_pend, bit_start, bit_end, field_end, last_led, last_end, start;

    led_bit_timer #(.DIV_WIDTH(DIV_WIDTH)) u_timer (
        .clk_sys   (clk_sys),
        .n_reset   (n_reset),
        .run       (busy),
        .div       (div_q),
        .clk_out   (clk_out),
        .bit_start (bit_start),
        .bit_end   (bit_end)
    );

    assign start     = state == IDLE && send_req && !done;
    assign field_end = bit_end && bcnt == (state == START ? 6'(APA102_START_BITS - 1) : 6'd7);
    assign last_led  = led_cnt == LED_WIDTH'(N_LEDS - 1);
    assign last_end  = led_cnt == LED_WIDTH'(END_BYTES - 1);

    always_ff @(posedge clk_sys or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? START : IDLE;
            START:   nxt = field_end ? HDR : START;
            HDR:     nxt = field_end ? BLUE : HDR;
            BLUE:    nxt = field_end ? GREEN : BLUE;
            GREEN:   nxt = field_end ? RED : GREEN;
            RED:     nxt = field_end ? (last_led ? END : HDR) : RED;
            END:     nxt = field_end && last_end ? IDLE : END;
            default: nxt = IDLE;
        endcase
    end

    // The next RAM byte is fetched on the first cycle of the field before it, so it is ready long before the load
    always_comb begin
        busy    = state != IDLE;
        sdo     = busy && sh[7];
        read_en = bit_start && bcnt == 6'd0 && (state == HDR || state == BLUE || state == GREEN);
    end

    always_ff @(posedge clk_sys or negedge n_reset) begin
        if (!n_reset) begin
            bri_q   <= '0;
            div_q   <= '0;
            raddr   <= '0;
            bcnt    <= '0;
            led_cnt <= '0;
            sh      <= '0;
            hold    <= '0;
            rd_pend <= 1'b0;
            done    <= 1'b0;
        end else begin
            done    <= state == END && nxt == IDLE;
            rd_pend <= read_en;
            if (rd_pend) hold <= rdata;
            if (start) begin
                bri_q   <= brightness;
                div_q   <= div;
                raddr   <= '0;
                bcnt    <= '0;
                led_cnt <= '0;
                sh      <= '0;
            end else begin
                if (read_en && raddr != LAST_ADDR) raddr <= raddr + ADDR_WIDTH'(1);
                if (bit_end) begin
                    bcnt <= field_end ? 6'd0 : bcnt + 6'd1;
                    sh   <= !field_end   ? {sh[6:0], state == END} :
                            nxt == HDR   ? {APA102_HDR_MARK, bri_q} :
                            nxt == END   ? 8'hFF :
                            nxt == IDLE  ? 8'h00 : hold;
                    // LED counter doubles as the end-frame byte counter
                    if (field_end && (state == RED || state == END))
                        led_cnt <= state == RED && last_led ? '0 : led_cnt + LED_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_led_strip_streamer.sv
// tb_led_strip_streamer: scoreboard bench, expected strip bits queued at stimulus and popped on clk_out rises
module tb_led_strip_streamer;
    logic clk_sys = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    logic       send_a = 1'b0, send_b = 1'b0;
    logic [4:0] bri_a = 5'h1F, bri_b = 5'h03;
    logic [3:0] div_a = 4'd0, div_b = 4'd0;
    logic [8:0] raddr_a, raddr_b;
    logic       re_a, re_b, clk_out_a, clk_out_b, sdo_a, sdo_b, busy_a, busy_b, done_a, done_b;
    logic [7:0] rdata_a = 8'h00, rdata_b = 8'h00;
    logic [7:0] mem_a [0:511];
    logic [7:0] mem_b [0:511];
    logic [7:0] frame_a [0:7] = '{8'hFF, 8'h10, 8'h20, 8'h30, 8'hFF, 8'h40, 8'h50, 8'h60};

    led_strip_streamer #(.N_LEDS(2)) dut_a (
        .clk_sys(clk_sys), .n_reset(n_reset), .send_req(send_a), .brightness(bri_a), .div(div_a),
        .raddr(raddr_a), .read_en(re_a), .rdata(rdata_a), .clk_out(clk_out_a), .sdo(sdo_a),
        .busy(busy_a), .done(done_a)
    );
    led_strip_streamer #(.N_LEDS(128)) dut_b (
        .clk_sys(clk_sys), .n_reset(n_reset), .send_req(send_b), .brightness(bri_b), .div(div_b),
        .raddr(raddr_b), .read_en(re_b), .rdata(rdata_b), .clk_out(clk_out_b), .sdo(sdo_b),
        .busy(busy_b), .done(done_b)
    );

    // RAM models: data valid only the cycle after read_en, garbage otherwise
    always @(posedge clk_sys) begin
        rdata_a <= re_a ? mem_a[raddr_a] : 8'hA5;
        rdata_b <= re_b ? mem_b[raddr_b] : 8'hA5;
    end

    bit q_a[$];
    bit q_b[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_byte_a(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) q_a.push_back(v[i]);
    endtask

    task automatic push_byte_b(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) q_b.push_back(v[i]);
    endtask

    task automatic push_frame_a();
        for (int i = 0; i < 32; i++) q_a.push_back(1'b0);
        for (int i = 0; i < 8; i++) push_byte_a(frame_a[i]);
        for (int i = 0; i < 8; i++) q_a.push_back(1'b1);
    endtask

    task automatic push_frame_b();
        for (int i = 0; i < 32; i++) q_b.push_back(1'b0);
        for (int l = 0; l < 128; l++) begin
            push_byte_b(8'hE3);
            for (int c = 0; c < 3; c++) push_byte_b(8'(3 * l + c) ^ 8'h5A);
        end
        for (int i = 0; i < 64; i++) q_b.push_back(1'b1);
    endtask

    task automatic pulse_a();
        @(posedge clk_sys);
        #1 send_a = 1'b1;
        @(posedge clk_sys);
        #1 send_a = 1'b0;
    endtask

    task automatic wait_done_a(input string name, input int limit);
        int n = 0;
        while (!done_a && n < limit) begin
            @(negedge clk_sys);
            n++;
        end
        check(name, int'(done_a), 1);
    endtask

    int exp_half = 1;
    int edges_a = 0, edges_b = 0, frames_a = 0, frames_b = 0, last_rd_b = -1;

    initial begin : mon_a
        bit prev = 1'b0;
        int run = 0, since = 0, exp;
        forever begin
            @(negedge clk_sys);
            if (!n_reset) begin
                prev = 1'b0;
                run = 0;
            end else begin
                if (re_a) check("a_raddr_range", int'(raddr_a < 9'd6), 1);
                if (clk_out_a && !prev) begin
                    edges_a++;
                    since = 0;
                    exp = 2;
                    if (q_a.size() > 0) exp = int'(q_a.pop_front());
                    check("a_sdo_bit", int'(sdo_a), exp);
                end else since++;
                if (busy_a) begin
                    if (clk_out_a != prev && run > 0) begin
                        check("a_half_period", run, exp_half);
                        run = 1;
                    end else run++;
                end else run = 0;
                if (done_a) begin
                    frames_a++;
                    check("a_done_busy", int'(busy_a), 0);
                    check("a_done_clk_sdo", int'({clk_out_a, sdo_a}), 0);
                    check("a_done_lag", since, exp_half);
                    check("a_bits_left", q_a.size(), 0);
                end
                prev = clk_out_a;
            end
        end
    end

    initial begin : mon_b
        bit prev = 1'b0;
        int exp;
        forever begin
            @(negedge clk_sys);
            if (!n_reset) prev = 1'b0;
            else begin
                if (re_b) begin
                    check("b_raddr_range", int'(raddr_b < 9'd384), 1);
                    last_rd_b = int'(raddr_b);
                end
                if (clk_out_b && !prev) begin
                    edges_b++;
                    exp = 2;
                    if (q_b.size() > 0) exp = int'(q_b.pop_front());
                    check("b_sdo_bit", int'(sdo_b), exp);
                end
                if (done_b) begin
                    frames_b++;
                    check("b_bits_left", q_b.size(), 0);
                    check("b_last_raddr", last_rd_b, 383);
                end
                prev = clk_out_b;
            end
        end
    end

    initial begin
        int e0, f0, n;
        for (int i = 0; i < 512; i++) begin
            mem_a[i] = 8'hEE;
            mem_b[i] = 8'(i) ^ 8'h5A;
        end
        mem_a[0] = 8'h10; mem_a[1] = 8'h20; mem_a[2] = 8'h30;
        mem_a[3] = 8'h40; mem_a[4] = 8'h50; mem_a[5] = 8'h60;
        repeat (3) @(negedge clk_sys);
        check("rst_outputs_a", int'({raddr_a, re_a, clk_out_a, sdo_a, busy_a, done_a}), 0);
        check("rst_outputs_b", int'({raddr_b, re_b, clk_out_b, sdo_b, busy_b, done_b}), 0);
        @(posedge clk_sys);
        #1 n_reset = 1'b1;

        // basic frame, div=0
        exp_half = 1;
        e0 = edges_a;
        push_frame_a();
        pulse_a();
        @(negedge clk_sys);
        check("t1_busy_after_req", int'(busy_a), 1);
        wait_done_a("t1_done", 2000);
        check("t1_edges", edges_a - e0, 104);

        // div=3, with div/brightness changed mid-frame
        repeat (3) @(posedge clk_sys);
        div_a = 4'd3;
        exp_half = 4;
        e0 = edges_a;
        push_frame_a();
        pulse_a();
        repeat (20) @(posedge clk_sys);
        #1 div_a = 4'd0;
        bri_a = 5'h01;
        wait_done_a("t2_done", 3000);
        check("t2_edges", edges_a - e0, 104);
        bri_a = 5'h1F;

        // send_req while busy and on the done cycle
        repeat (3) @(posedge clk_sys);
        exp_half = 1;
        f0 = frames_a;
        push_frame_a();
        pulse_a();
        repeat (10) @(posedge clk_sys);
        pulse_a();
        repeat (30) @(posedge clk_sys);
        pulse_a();
        wait_done_a("t3_done", 2000);
        send_a = 1'b1;
        @(posedge clk_sys);
        #1 send_a = 1'b0;
        repeat (300) @(negedge clk_sys);
        check("t3_frames", frames_a - f0, 1);
        check("t3_idle_busy", int'(busy_a), 0);

        // reset after the 50th bit, then a clean restart
        e0 = edges_a;
        push_frame_a();
        pulse_a();
        n = 0;
        while (edges_a - e0 < 50 && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        check("t4_reached_50", int'(edges_a - e0 >= 50), 1);
        q_a.delete();
        n_reset = 1'b0;
        @(negedge clk_sys);
        check("t4_rst_clk_sdo_busy", int'({clk_out_a, sdo_a, busy_a}), 0);
        check("t4_rst_raddr", int'(raddr_a), 0);
        @(posedge clk_sys);
        #1 n_reset = 1'b1;
        e0 = edges_a;
        push_frame_a();
        pulse_a();
        wait_done_a("t4_done", 2000);
        check("t4_edges", edges_a - e0, 104);

        // 128 LEDs, brightness 3
        push_frame_b();
        @(posedge clk_sys);
        #1 send_b = 1'b1;
        @(posedge clk_sys);
        #1 send_b = 1'b0;
        n = 0;
        while (!done_b && n < 12000) begin
            @(negedge clk_sys);
            n++;
        end
        check("t5_done", int'(done_b), 1);
        check("t5_edges", edges_b, 4192);
        repeat (3) @(negedge clk_sys);
        check("t5_frames", frames_b, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
